key_motion_sequencer: RTL and testbench
=======================================

Name: key_motion_sequencer

Overview:
Sits between the PS/2 byte receiver and object_host. It decodes make/break scan-code sequences into a held-key vector for six movement/rotation keys. On a periodic step tick it emits at most one move pulse and one rotate pulse, gated by the per-direction collision enables from ray_tracer_host. This converts asynchronous key traffic into frame-rate-paced, collision-safe motion commands.

Parameters:
TICK_CYCLES, 262144, clk cycles between step ticks (>=2)
TICK_W, 18, width of tick counter (must hold TICK_CYCLES-1)

Ports:
clk  in  1  system clock (tracer domain, clkdiv[0])
rst  in  1  reset; asynchronous, active-low
scan_code  in  8  byte from PS/2 receiver
scan_valid  in  1  one-cycle strobe, scan_code valid
en_forward  in  1  1 = forward move permitted (no collision)
en_backward  in  1  1 = backward permitted
en_left  in  1  1 = strafe-left permitted
en_right  in  1  1 = strafe-right permitted
move_step  out  1  one-cycle pulse, execute move
move_dir  out  2  00 fwd, 01 back, 10 left, 11 right; valid with move_step
rotate_sig  out  2  00 none, 01 ccw, 10 cw, 11 never driven; non-zero for exactly one cycle per tick
blocked  out  1  one-cycle pulse: move wanted but enable low
key_state  out  6  held keys {E,Q,D,A,S,W}, bit0 = W

Behaviour:
- Reset (rst=0, async): decoder state IDLE, key_state=0, tick counter=0, move_step=0, move_dir=00, rotate_sig=00, blocked=0.
- Scan codes: W=1D, S=1B, A=1C, D=23, Q=15 (ccw), E=24 (cw).
- Decoder FSM, advances only on scan_valid:
  - IDLE: F0->BREAK; E0->EXT; known code->set bit, stay; other->ignore.
  - BREAK: any byte; known->clear bit; ->IDLE.
  - EXT: F0->EXT_BREAK; else handle extended make ->IDLE.
  - EXT_BREAK: handle extended break ->IDLE.
- key_state updates the cycle after scan_valid. Repeated make of a held key is a no-op. Break of a non-held key is a no-op.
- Tick: counter runs 0..TICK_CYCLES-1 and wraps. tick asserts combinationally when counter==TICK_CYCLES-1.
- Outputs are registered: pulses appear the cycle after tick and last exactly one cycle.
- On tick, evaluate registered key_state and en_* sampled that cycle:
  - Move candidate, priority W > S > A > D.
  - If the candidate's enable=1: move_step=1, move_dir=its code.
  - If the candidate's enable=0: blocked=1, move_step=0, and no fallback to a lower-priority key.
  - Rotate: Q only -> 01; E only -> 10; both or neither -> 00.
- If scan_valid coincides with tick, the tick uses the pre-update key_state.
- move_dir holds its last value between pulses.
- rst asserted mid-sequence (e.g. after F0) discards the partial sequence; no output is generated from it.

Optional Feature:
ARROW_KEYS_EN
- Defined: extended codes E0 75 = forward, E0 72 = backward, E0 6B = rotate ccw, E0 74 = rotate cw.
  - Each arrow shares the key_state bit of W/S/Q/E respectively (OR semantics: both the arrow and the letter set/clear the same bit).
  - Breaking either clears the bit.
- Undefined: every E0-prefixed sequence is consumed (FSM still walks EXT/EXT_BREAK) and ignored.

Decomposition:
- Package vtracer_ctrl_pkg:
  - scan-code constants (make codes, F0, E0, arrow codes)
  - move_dir encodings (DIR_FWD/BACK/LEFT/RIGHT)
  - rotate encodings (ROT_NONE/CCW/CW)
  - key_state bit indices
- One sub-module: ps2_key_tracker. Holds the FSM plus key_state; outputs key_state.
- Top of block: tick counter and step arbitration.

Test Plan:
- TICK_CYCLES=8, all en_*=1. Send 1D. Then ~2 ticks' pulses: move_step=1, move_dir=00 each tick, rotate_sig=00. Send F0,1D: pulses stop from the next tick onward.
- Hold W and S. Keep en_forward=0, en_backward=1: each tick gives blocked=1, move_step=0 (no fallback to S).
- Hold Q and E: rotate_sig stays 00. Release E (F0 24): next tick rotate_sig=01 for one cycle.
- Send F0 then assert rst mid-sequence. Then send 1D: key W is set, not cleared; key_state=000001.
- Send 1D with scan_valid in the same cycle as tick: no pulse that tick, move_step at the next tick.
- ARROW_KEYS_EN on: E0 75 gives key_state[0]=1 and forward pulses. With it off: E0 75 leaves key_state=0, and a following 1D is still decoded correctly.

Source files
------------

// File: rtl/vtracer_ctrl_pkg.sv
// Shared constants for the key/motion control path: PS/2 scan codes,
// move/rotate encodings, key_state bit indices and decode helpers.
package vtracer_ctrl_pkg;

  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_Q       = 8'h15;
  localparam logic [7:0] SC_E       = 8'h24;
  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;

  localparam logic [1:0] DIR_FWD    = 2'b00;
  localparam logic [1:0] DIR_BACK   = 2'b01;
  localparam logic [1:0] DIR_LEFT   = 2'b10;
  localparam logic [1:0] DIR_RIGHT  = 2'b11;

  localparam logic [1:0] ROT_NONE   = 2'b00;
  localparam logic [1:0] ROT_CCW    = 2'b01;
  localparam logic [1:0] ROT_CW     = 2'b10;

  localparam int unsigned KEY_W = 0;
  localparam int unsigned KEY_S = 1;
  localparam int unsigned KEY_A = 2;
  localparam int unsigned KEY_D = 3;
  localparam int unsigned KEY_Q = 4;
  localparam int unsigned KEY_E = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } dec_state_t;

  // One-hot key_state mask for a plain (non-E0) code; zero if unknown.
  function automatic logic [5:0] letter_mask(input logic [7:0] code);
    logic [5:0] m;
    m = '0;
    case (code)
      SC_W:    m[KEY_W] = 1'b1;
      SC_S:    m[KEY_S] = 1'b1;
      SC_A:    m[KEY_A] = 1'b1;
      SC_D:    m[KEY_D] = 1'b1;
      SC_Q:    m[KEY_Q] = 1'b1;
      SC_E:    m[KEY_E] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Arrow keys alias onto the W/S/Q/E bits.
  function automatic logic [5:0] arrow_mask(input logic [7:0] code);
    logic [5:0] m;
    m = '0;
    case (code)
      SC_UP:    m[KEY_W] = 1'b1;
      SC_DOWN:  m[KEY_S] = 1'b1;
      SC_LEFT:  m[KEY_Q] = 1'b1;
      SC_RIGHT: m[KEY_E] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// Make/break scan-code decoder producing the held-key vector.
// Optional macro ARROW_KEYS_EN maps E0-prefixed arrow codes onto W/S/Q/E.
module ps2_key_tracker
  import vtracer_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [5:0] key_state
);

  dec_state_t state;
  logic [5:0] plain_mask;
  logic [5:0] ext_mask;

  always_comb begin
    plain_mask = letter_mask(scan_code);
`ifdef ARROW_KEYS_EN
    ext_mask = arrow_mask(scan_code);
`else
    ext_mask = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      key_state <= '0;
    end else if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)    state <= ST_BREAK;
          else if (scan_code == SC_EXT) state <= ST_EXT;
          else                          key_state <= key_state | plain_mask;
        end
        ST_BREAK: begin
          key_state <= key_state & ~plain_mask;
          state     <= ST_IDLE;
        end
        ST_EXT: begin
          if (scan_code == SC_BREAK) begin
            state <= ST_EXT_BREAK;
          end else begin
            key_state <= key_state | ext_mask;
            state     <= ST_IDLE;
          end
        end
        ST_EXT_BREAK: begin
          key_state <= key_state & ~ext_mask;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_motion_sequencer.sv
// Converts held keys into tick-paced move/rotate pulses gated by collision enables.
// Optional macro ARROW_KEYS_EN (in ps2_key_tracker) adds arrow-key aliases.
module key_motion_sequencer
  import vtracer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 262144,
  parameter int unsigned TICK_W      = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       en_forward,
  input  logic       en_backward,
  input  logic       en_left,
  input  logic       en_right,
  output logic       move_step,
  output logic [1:0] move_dir,
  output logic [1:0] rotate_sig,
  output logic       blocked,
  output logic [5:0] key_state
);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              cand_valid;
  logic              cand_en;
  logic [1:0]        cand_dir;
  logic [1:0]        rot_next;

  ps2_key_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .key_state (key_state)
  );

  assign tick = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Highest-priority held move key; its own enable decides, no fallback.
  always_comb begin
    cand_valid = 1'b1;
    cand_en    = 1'b0;
    cand_dir   = DIR_FWD;
    if (key_state[KEY_W]) begin
      cand_dir = DIR_FWD;   cand_en = en_forward;
    end else if (key_state[KEY_S]) begin
      cand_dir = DIR_BACK;  cand_en = en_backward;
    end else if (key_state[KEY_A]) begin
      cand_dir = DIR_LEFT;  cand_en = en_left;
    end else if (key_state[KEY_D]) begin
      cand_dir = DIR_RIGHT; cand_en = en_right;
    end else begin
      cand_valid = 1'b0;
    end

    case ({key_state[KEY_E], key_state[KEY_Q]})
      2'b01:   rot_next = ROT_CCW;
      2'b10:   rot_next = ROT_CW;
      default: rot_next = ROT_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_step  <= 1'b0;
      move_dir   <= DIR_FWD;
      rotate_sig <= ROT_NONE;
      blocked    <= 1'b0;
    end else begin
      move_step  <= 1'b0;
      blocked    <= 1'b0;
      rotate_sig <= ROT_NONE;
      if (tick) begin
        rotate_sig <= rot_next;
        if (cand_valid) begin
          if (cand_en) begin
            move_step <= 1'b1;
            move_dir  <= cand_dir;
          end else begin
            blocked <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_key_motion_sequencer.sv
// Scoreboard bench for key_motion_sequencer with an 8-cycle step tick.
module tb_key_motion_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       en_forward = 1'b1, en_backward = 1'b1, en_left = 1'b1, en_right = 1'b1;
  logic       move_step, blocked;
  logic [1:0] move_dir, rotate_sig;
  logic [5:0] key_state;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       step;
    logic       blk;
    logic [1:0] rot;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [5:0] mk = '0;
  int         mcnt = 0;
  int         ph = 0;
  logic [1:0] mdir = 2'b00;

  key_motion_sequencer #(.TICK_CYCLES(8), .TICK_W(3)) dut (
    .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
    .en_forward(en_forward), .en_backward(en_backward),
    .en_left(en_left), .en_right(en_right),
    .move_step(move_step), .move_dir(move_dir), .rotate_sig(rotate_sig),
    .blocked(blocked), .key_state(key_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic int plain_bit(input logic [7:0] c);
    case (c)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      8'h15: return 4;
      8'h24: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int ext_bit(input logic [7:0] c);
`ifdef ARROW_KEYS_EN
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 4;
      8'h74: return 5;
      default: return -1;
    endcase
`else
    return (c == 8'hFF) ? -2 : -1;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One clock: caller sits at a negedge; drive, model, check after posedge.
  task automatic cycle(input logic [7:0] c, input logic v);
    exp_t e;
    int   b, x;
    scan_code  = c;
    scan_valid = v;
    e = '0;
    if (mcnt == 7) begin
      if      (mk[0]) begin if (en_forward)  begin e.step = 1; mdir = 2'b00; end else e.blk = 1; end
      else if (mk[1]) begin if (en_backward) begin e.step = 1; mdir = 2'b01; end else e.blk = 1; end
      else if (mk[2]) begin if (en_left)     begin e.step = 1; mdir = 2'b10; end else e.blk = 1; end
      else if (mk[3]) begin if (en_right)    begin e.step = 1; mdir = 2'b11; end else e.blk = 1; end
      e.rot = (mk[4] && !mk[5]) ? 2'b01 : (mk[5] && !mk[4]) ? 2'b10 : 2'b00;
    end
    exp_q.push_back(e);
    mcnt = (mcnt + 1) % 8;
    if (v) begin
      b = plain_bit(c);
      x = ext_bit(c);
      case (ph)
        0: if (c == 8'hF0) ph = 1; else if (c == 8'hE0) ph = 2; else if (b >= 0) mk[b] = 1'b1;
        1: begin if (b >= 0) mk[b] = 1'b0; ph = 0; end
        2: if (c == 8'hF0) ph = 3; else begin if (x >= 0) mk[x] = 1'b1; ph = 0; end
        default: begin if (x >= 0) mk[x] = 1'b0; ph = 0; end
      endcase
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("key_state",  {2'b00, key_state},  {2'b00, mk});
    check("move_step",  {7'd0, move_step},   {7'd0, e.step});
    check("blocked",    {7'd0, blocked},     {7'd0, e.blk});
    check("rotate_sig", {6'd0, rotate_sig},  {6'd0, e.rot});
    check("move_dir",   {6'd0, move_dir},    {6'd0, mdir});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] c);
    cycle(c, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    scan_valid = 1'b0;
    #1;
    mk = '0; mcnt = 0; ph = 0; mdir = 2'b00;
    exp_q.delete();
    check("rst_key_state",  {2'b00, key_state}, 8'h00);
    check("rst_move_step",  {7'd0, move_step},  8'h00);
    check("rst_move_dir",   {6'd0, move_dir},   8'h00);
    check("rst_rotate_sig", {6'd0, rotate_sig}, 8'h00);
    check("rst_blocked",    {7'd0, blocked},    8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Forward pulses while W held, stop after release
    send(8'h1D); idle(18);
    send(8'hF0); send(8'h1D); idle(16);

    // W and S held, forward blocked: no fallback to S
    en_forward = 1'b0;
    send(8'h1D); send(8'h1B); idle(16);
    send(8'hF0); send(8'h1D); idle(9);
    send(8'hF0); send(8'h1B);
    en_forward = 1'b1;

    // A then D with strafe enables toggled
    en_left = 1'b0;
    send(8'h1C); send(8'h23); idle(9);
    en_left = 1'b1; idle(9);
    send(8'hF0); send(8'h1C); idle(9);
    send(8'hF0); send(8'h23);

    // Q+E cancel, releasing E leaves ccw
    send(8'h15); send(8'h24); idle(10);
    send(8'hF0); send(8'h24); idle(10);
    send(8'hF0); send(8'h15); idle(2);

    // Repeat make / stray break are no-ops; unknown code ignored
    send(8'h1D); send(8'h1D); send(8'hF0); send(8'h23); send(8'h5A); idle(3);
    send(8'hF0); send(8'h1D);

    // Reset mid-break sequence discards the pending F0
    send(8'hF0);
    do_reset();
    send(8'h1D); idle(10);
    send(8'hF0); send(8'h1D); idle(3);

    // Make coincident with tick: pulse only on the following tick
    while (mcnt != 7) idle(1);
    send(8'h1D); idle(9);
    send(8'hF0); send(8'h1D); idle(2);

    // Extended sequences: arrows when enabled, consumed otherwise
    send(8'hE0); send(8'h75); idle(10);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    send(8'hE0); send(8'h6B); idle(9);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'h1D); idle(9);
    send(8'hF0); send(8'h1D); idle(9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
